// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and data-memory
// wait freezes, with a sticky memory-timeout flag.
// Optional performance counters are built when HAZARD_CTRL_PERF_CNT_EN is defined;
// otherwise the count outputs are tied to zero.
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rt_i,
    input  logic [4:0]  ifid_rs_i,
    input  logic [4:0]  ifid_rt_i,
    input  logic        branch_taken_i,
    input  logic        jump_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        ctrl_bubble_o,
    output logic        pipe_freeze_o,
    output logic        err_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] memwait_cnt_o
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StMemWait = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;

    logic load_use;
    logic redirect;
    logic mem_stall;
    logic stall_evt;
    logic memwait_evt;

    assign load_use  = idex_memread_i & (idex_rt_i != 5'd0) &
                       ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
    assign redirect  = branch_taken_i | jump_i;
    assign mem_stall = mem_req_i & ~mem_ack_i;

    // Next-state and output decode; RUN outputs follow the current inputs directly.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        err_d         = err_q;
        stall_evt     = 1'b0;
        memwait_evt   = 1'b0;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        ctrl_bubble_o = 1'b1;
        pipe_freeze_o = 1'b1;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                pc_write_o    = 1'b1;
                ifid_write_o  = 1'b1;
                ctrl_bubble_o = 1'b0;
                pipe_freeze_o = 1'b0;
                if (mem_stall) begin
                    // An outstanding data access outranks everything, including start_i.
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    pipe_freeze_o = 1'b1;
                    wait_cnt_d    = 8'd0;
                    state_d       = StMemWait;
                end else begin
                    if (load_use) begin
                        pc_write_o    = 1'b0;
                        ifid_write_o  = 1'b0;
                        ctrl_bubble_o = 1'b1;
                        stall_evt     = 1'b1;
                    end else if (redirect) begin
                        ifid_flush_o = 1'b1;
                    end
                    if (!start_i) begin
                        state_d = StIdle;
                    end
                end
            end
            StMemWait: begin
                ctrl_bubble_o = 1'b0;
                memwait_evt   = 1'b1;
                wait_cnt_d    = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
                if (wait_cnt_d == 8'hFF) begin
                    err_d = 1'b1;
                end
                // start_i is deliberately ignored until the access completes.
                if (mem_ack_i) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

    // Performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q   <= 32'd0;
            flush_cnt_q   <= 32'd0;
            memwait_cnt_q <= 32'd0;
        end else begin
            if (stall_evt) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ifid_flush_o) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if (memwait_evt) begin
                memwait_cnt_q <= memwait_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign memwait_cnt_o = memwait_cnt_q;
`else
    logic unused_evt;
    assign unused_evt    = stall_evt ^ memwait_evt;
    assign stall_cnt_o   = 32'd0;
    assign flush_cnt_o   = 32'd0;
    assign memwait_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Expected counter values assume the counters are built
// when HAZARD_CTRL_PERF_CNT_EN is defined and are zero otherwise.
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        idex_memread_i;
    logic [4:0]  idex_rt_i;
    logic [4:0]  ifid_rs_i;
    logic [4:0]  ifid_rt_i;
    logic        branch_taken_i;
    logic        jump_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        ifid_flush_o;
    logic        ctrl_bubble_o;
    logic        pipe_freeze_o;
    logic        err_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
    logic [31:0] memwait_cnt_o;

    int checks = 0;
    int errors = 0;

`ifdef HAZARD_CTRL_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    // {pc_write, ifid_write, ifid_flush, ctrl_bubble, pipe_freeze}
    localparam logic [4:0] OIdle   = 5'b00011;
    localparam logic [4:0] ORun    = 5'b11000;
    localparam logic [4:0] OStall  = 5'b00010;
    localparam logic [4:0] OFlush  = 5'b11100;
    localparam logic [4:0] OFreeze = 5'b00001;

    hazard_ctrl u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .branch_taken_i (branch_taken_i),
        .jump_i         (jump_i),
        .mem_req_i      (mem_req_i),
        .mem_ack_i      (mem_ack_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .ctrl_bubble_o  (ctrl_bubble_o),
        .pipe_freeze_o  (pipe_freeze_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .memwait_cnt_o  (memwait_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        #1;
        obs = {pc_write_o, ifid_write_o, ifid_flush_o, ctrl_bubble_o, pipe_freeze_o};
        chk(tag, {27'd0, obs}, {27'd0, exp});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_in();
        idex_memread_i = 1'b0;
        idex_rt_i      = 5'd0;
        ifid_rs_i      = 5'd0;
        ifid_rt_i      = 5'd0;
        branch_taken_i = 1'b0;
        jump_i         = 1'b0;
        mem_req_i      = 1'b0;
        mem_ack_i      = 1'b0;
    endtask

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        clear_in();
        #1;
        chk_outs("reset_outs", OIdle);
        chk("reset_err", {31'd0, err_o}, 32'd0);
        chk("reset_stall_cnt", stall_cnt_o, 32'd0);
        step();
        step();
        rst_i = 1'b0;

        // Held in IDLE while start_i is low.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outs("idle_hold", OIdle);
        end
        start_i = 1'b1;
        chk_outs("idle_start_same_cycle", OIdle);
        step();
        chk_outs("run_entry", ORun);

        // Load-use via rs, then via rt, then with rt=0 (no hazard).
        idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8;
        chk_outs("load_use_rs", OStall);
        step();
        clear_in();
        chk_outs("after_load_use", ORun);
        chk("stall_cnt_1", stall_cnt_o, Perf ? 32'd1 : 32'd0);
        idex_memread_i = 1'b1; idex_rt_i = 5'd0; ifid_rs_i = 5'd0;
        chk_outs("load_use_r0", ORun);
        idex_rt_i = 5'd5; ifid_rt_i = 5'd5;
        chk_outs("load_use_rt", OStall);
        step();
        clear_in();

        // Load-use outranks branch; then branch alone, then jump alone.
        idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8; branch_taken_i = 1'b1;
        chk_outs("prio_load_use_branch", OStall);
        step();
        clear_in();
        branch_taken_i = 1'b1;
        chk_outs("branch_flush", OFlush);
        step();
        clear_in();
        chk("flush_cnt_1", flush_cnt_o, Perf ? 32'd1 : 32'd0);
        chk("stall_cnt_3", stall_cnt_o, Perf ? 32'd3 : 32'd0);
        jump_i = 1'b1;
        chk_outs("jump_flush", OFlush);
        step();
        clear_in();
        chk("flush_cnt_2", flush_cnt_o, Perf ? 32'd2 : 32'd0);

        // Stray ack and acked request cause no stall.
        mem_ack_i = 1'b1;
        chk_outs("ack_without_req", ORun);
        mem_req_i = 1'b1;
        chk_outs("req_with_ack", ORun);
        step();
        clear_in();

        // Memory wait: 4 cycles ack low then ack high, freeze throughout.
        mem_req_i = 1'b1;
        idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8; branch_taken_i = 1'b1;
        chk_outs("memwait_prio", OFreeze);
        step();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            chk_outs("memwait_hold", OFreeze);
            step();
        end
        mem_ack_i = 1'b1;
        chk_outs("memwait_ack_cycle", OFreeze);
        step();
        clear_in();
        chk_outs("memwait_back_run", ORun);
        chk("memwait_cnt_4", memwait_cnt_o, Perf ? 32'd4 : 32'd0);
        chk("stall_cnt_after_mw", stall_cnt_o, Perf ? 32'd3 : 32'd0);

        // start_i dropped during MEMWAIT: wait finishes, RUN, then IDLE.
        mem_req_i = 1'b1;
        step();
        clear_in();
        start_i = 1'b0;
        chk_outs("mw_start_low", OFreeze);
        step();
        chk_outs("mw_start_ignored", OFreeze);
        mem_ack_i = 1'b1;
        step();
        clear_in();
        chk_outs("mw_then_run", ORun);
        step();
        chk_outs("run_to_idle", OIdle);
        chk("memwait_cnt_6", memwait_cnt_o, Perf ? 32'd6 : 32'd0);
        start_i = 1'b1;
        step();
        chk_outs("restart_run", ORun);

        // Timeout: err_o sets after exactly 255 MEMWAIT cycles.
        mem_req_i = 1'b1;
        step();
        clear_in();
        for (int i = 0; i < 254; i++) begin
            step();
        end
        chk("timeout_not_yet", {31'd0, err_o}, 32'd0);
        step();
        chk("timeout_set", {31'd0, err_o}, 32'd1);
        chk_outs("timeout_still_frozen", OFreeze);
        mem_ack_i = 1'b1;
        step();
        clear_in();
        chk_outs("timeout_ack_run", ORun);
        chk("timeout_sticky", {31'd0, err_o}, 32'd1);
        chk("memwait_cnt_262", memwait_cnt_o, Perf ? 32'd262 : 32'd0);

        // Asynchronous reset between edges while in MEMWAIT.
        mem_req_i = 1'b1;
        step();
        clear_in();
        chk_outs("pre_async_rst", OFreeze);
        #2;
        rst_i = 1'b1;
        chk_outs("async_rst_outs", OIdle);
        chk("async_rst_err", {31'd0, err_o}, 32'd0);
        chk("async_rst_stall", stall_cnt_o, 32'd0);
        chk("async_rst_flush", flush_cnt_o, 32'd0);
        chk("async_rst_memwait", memwait_cnt_o, 32'd0);
        start_i = 1'b0;
        step();
        rst_i = 1'b0;
        step();
        chk_outs("post_rst_idle", OIdle);
        start_i = 1'b1;
        step();
        chk_outs("post_rst_run", ORun);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk_i  in  1  pipeline clock; all state updates on its rising edge.
REQ-002 rst_i  in  1  reset, asynchronous, active-high.
REQ-003 start_i  in  1  CPU run enable; level-sensitive, sampled on clk_i.
REQ-004 idex_memread_i  in  1  the instruction in ID/EX is a load.
REQ-005 idex_rt_i  in  5  destination register of the load in ID/EX.
REQ-006 ifid_rs_i / ifid_rt_i  in  5 each  source registers of the instruction in IF/ID.
REQ-007 branch_taken_i / jump_i  in  1 each  ID-stage redirect (taken beq, or j).
REQ-008 mem_req_i  in  1  the EX/MEM instruction accesses data memory this cycle.
REQ-009 mem_ack_i  in  1  data memory completed the access this cycle.
REQ-010 pc_write_o  out  1  PC update enable.
REQ-011 ifid_write_o  out  1  IF/ID register write enable.
REQ-012 ifid_flush_o  out  1  zero the IF/ID instruction.
REQ-013 ctrl_bubble_o  out  1  force ID-stage control signals to 0 (bubble into ID/EX).
REQ-014 pipe_freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-015 err_o  out  1  sticky memory-timeout flag.
REQ-016 stall_cnt_o / flush_cnt_o / memwait_cnt_o  out  32 each  performance counters.

Function
REQ-017 FSM states: IDLE, RUN, MEMWAIT; 2-bit state register.
REQ-018 IDLE: pc_write_o=0, ifid_write_o=0, ctrl_bubble_o=1, pipe_freeze_o=1, ifid_flush_o=0. When start_i=1 at an edge, next state is RUN.
REQ-019 load_use = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
REQ-020 RUN defaults: pc_write_o=1, ifid_write_o=1, ctrl_bubble_o=0, pipe_freeze_o=0, ifid_flush_o=0.
REQ-021 Outputs in RUN are combinational from the current inputs (0-cycle latency).
REQ-022 RUN with load_use: pc_write_o=0, ifid_write_o=0, ctrl_bubble_o=1 for exactly the cycle in which load_use is true.
REQ-023 RUN with (branch_taken_i | jump_i) and no load_use: ifid_flush_o=1. Load_use takes priority and suppresses the flush for that cycle.
REQ-024 RUN with mem_req_i=1 and mem_ack_i=0:
  - pipe_freeze_o=1, pc_write_o=0, ifid_write_o=0 in the same cycle;
  - ifid_flush_o and ctrl_bubble_o are forced to 0;
  - next state is MEMWAIT.
  The memory wait has priority over load_use and over the flush.
REQ-025 RUN with mem_req_i=1 and mem_ack_i=1: no stall; outputs follow REQ-020 to REQ-023.
REQ-026 MEMWAIT outputs: pipe_freeze_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, ctrl_bubble_o=0.
REQ-027 MEMWAIT with mem_ack_i=1: the current cycle stays frozen and the next state is RUN.
REQ-028 MEMWAIT wait counter (8-bit):
  - clears on entry to MEMWAIT;
  - increments each MEMWAIT cycle and saturates at 255;
  - when it reaches 255, err_o is set and stays 1 until reset;
  - the FSM keeps waiting for mem_ack_i.
REQ-029 start_i=0 at an edge in RUN: next state is IDLE. In MEMWAIT, start_i is ignored until the ack arrives; the FSM then returns to RUN, and goes to IDLE only if start_i is still 0 there.
REQ-030 mem_ack_i while mem_req_i=0 in RUN is ignored.

Reset
REQ-031 On rst_i=1 the following apply immediately, independent of clk_i:
  - state=IDLE, wait counter=0, err_o=0, all counters=0;
  - outputs take the IDLE values of REQ-018.
REQ-032 Reset asserted during MEMWAIT abandons the wait. After release the FSM re-enters RUN only via start_i.

Configuration
REQ-033 Macro HAZARD_CTRL_PERF_CNT_EN defined:
  - stall_cnt_o increments each RUN cycle that REQ-022 applies;
  - flush_cnt_o increments each cycle ifid_flush_o=1;
  - memwait_cnt_o increments each MEMWAIT cycle;
  - all three wrap modulo 2^32.
REQ-034 Macro undefined: no counter flops are built, the three count outputs are constant 0, and the ports remain present.

Verification
REQ-035 Reset and start: rst_i=1, then release with start_i=0 for 3 cycles -> IDLE outputs held (pc_write_o=0, pipe_freeze_o=1). start_i=1 -> RUN on the next edge with pc_write_o=1.
REQ-036 Load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 for 1 cycle -> pc_write_o=0, ifid_write_o=0, ctrl_bubble_o=1 for 1 cycle; stall_cnt_o=1. Same stimulus with idex_rt_i=0 -> no stall.
REQ-037 Priority: load_use and branch_taken_i both 1 -> ifid_flush_o=0, stall asserted. The next cycle, branch only -> ifid_flush_o=1; flush_cnt_o=1.
REQ-038 Memory wait: mem_req_i=1 with mem_ack_i low for 4 cycles, then high -> pipe_freeze_o=1 for 5 cycles total, then RUN; memwait_cnt_o=4.
REQ-039 Timeout: mem_req_i=1 and mem_ack_i never asserted -> err_o=1 after 255 MEMWAIT cycles and stays 1 after a later ack; rst_i clears it.
REQ-040 Async reset mid-MEMWAIT, applied between clock edges -> outputs go to IDLE values before the next edge; all counters read 0 (with HAZARD_CTRL_PERF_CNT_EN).
